stats_uart_tx: RTL and testbench

- Telemetry transmitter: the transmit-side counterpart to the existing UART receive path.
- Periodically, or on request, snapshots the six pet stats plus the status vector.
- Serializes the snapshot as a fixed byte frame on an 8N1 UART line.
- Sits beside the stats/states blocks; drives a spare output pin for host-side logging.

---
 rtl/stats_uart_tx_pkg.sv | 59 +++++
 rtl/stats_uart_tx_if.sv | 26 ++
 rtl/stats_uart_tx_byte_tx.sv | 96 +++++++++
 rtl/stats_uart_tx.sv | 108 ++++++++++
 tb/tb_stats_uart_tx.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stats_uart_tx_pkg.sv
// Shared types and constants for the stats telemetry UART transmitter.
// Holds the frame header, FSM encodings, snapshot layout and frame byte lookup.
// Optional checksum byte enabled by defining STATS_TX_CHECKSUM_EN.
package stats_uart_tx_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

`ifdef STATS_TX_CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif

  typedef enum logic {
    F_IDLE,
    F_SEND
  } frame_state_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_e;

  // Frozen copy of the pet stats taken when a frame starts.
  typedef struct packed {
    logic [3:0] hunger;
    logic [3:0] happiness;
    logic [3:0] health;
    logic [3:0] hygiene;
    logic [3:0] energy;
    logic [3:0] social;
    logic [6:0] status;
  } snap_t;

  // Byte idx of the frame built from a snapshot.
  function automatic logic [7:0] frame_byte(input snap_t s, input logic [2:0] idx);
    logic [7:0] b1, b2, b3, b4;
    logic [7:0] res;
    b1 = {s.hunger, s.happiness};
    b2 = {s.health, s.hygiene};
    b3 = {s.energy, s.social};
    b4 = {1'b0, s.status};
    case (idx)
      3'd0:    res = FRAME_HDR;
      3'd1:    res = b1;
      3'd2:    res = b2;
      3'd3:    res = b3;
      3'd4:    res = b4;
`ifdef STATS_TX_CHECKSUM_EN
      3'd5:    res = FRAME_HDR ^ b1 ^ b2 ^ b3 ^ b4;
`endif
      default: res = 8'hFF;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stats_uart_tx_if.sv
// Stats/status inputs, report request and UART/status outputs of the transmitter.
// No latency of its own; plain wires between driver and transmitter.
// No backpressure: send_req is a level request, busy/frame_done report progress.
interface stats_uart_tx_if;
  logic [3:0] hunger;
  logic [3:0] happiness;
  logic [3:0] health;
  logic [3:0] hygiene;
  logic [3:0] energy;
  logic [3:0] social;
  logic [6:0] status;
  logic       send_req;
  logic       uart_tx;
  logic       busy;
  logic       frame_done;

  modport master (
    output hunger, happiness, health, hygiene, energy, social, status, send_req,
    input  uart_tx, busy, frame_done
  );

  modport slave (
    input  hunger, happiness, health, hygiene, energy, social, status, send_req,
    output uart_tx, busy, frame_done
  );
endinterface

// File: rtl/stats_uart_tx_byte_tx.sv
// uart_byte_tx: 8N1 serializer for one byte, LSB first, CLKS_PER_BIT cycles per bit.
// Latency: tx falls the cycle after start is accepted; 10*CLKS_PER_BIT cycles per byte.
// Backpressure: ready also high in the last stop-bit cycle so bytes chain with no gap.
module uart_byte_tx
  import stats_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  byte_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign ready   = (state_q == B_IDLE) || ((state_q == B_STOP) && bit_end);
  assign done    = (state_q == B_STOP) && bit_end;
  assign tx      = tx_q;

  // Bit timing and line level: advance state at the end of each bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      B_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
      end
      B_START: begin
        if (bit_end) begin
          state_d = B_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      B_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = B_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
      B_STOP: begin
        if (bit_end) begin
          state_d = B_IDLE;
        end
      end
      default: state_d = B_IDLE;
    endcase
    if (start && ready) begin
      state_d = B_START;
      cnt_d   = '0;
      shreg_d = data;
      tx_d    = 1'b0;
    end
  end

  // State register; reset forces the line idle immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= B_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/stats_uart_tx.sv
// stats_uart_tx: snapshots pet stats periodically or on request, sends them as a UART frame.
// Latency: request sampled at N -> snapshot at N+1 -> start bit at N+2; frame NBYTES*10*CLKS_PER_BIT.
// Backpressure: none; requests and period wraps during a frame coalesce into one follow-up.
// Defining STATS_TX_CHECKSUM_EN appends an XOR checksum byte (6-byte frame).
module stats_uart_tx
  import stats_uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT  = 87,
  parameter logic [23:0] REPORT_PERIOD = 24'd10_000_000
) (
  input  logic           clk,
  input  logic           reset,
  stats_uart_tx_if.slave bus
);

  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  frame_state_e state_q, state_d;
  snap_t        snap_q, snap_d, snap_in;
  logic [2:0]   issue_idx_q, issue_idx_d;
  logic         all_issued_q, all_issued_d;
  logic         pending_q, pending_d;
  logic [23:0]  period_q, period_d;
  logic         frame_done_q, frame_done_d;
  logic         frame_start, wrap, byte_start, byte_ready, byte_done, byte_tx;

  assign snap_in = '{hunger: bus.hunger, happiness: bus.happiness, health: bus.health,
                     hygiene: bus.hygiene, energy: bus.energy, social: bus.social,
                     status: bus.status};

  // Period counter, pending flag and frame sequencing.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    issue_idx_d  = issue_idx_q;
    all_issued_d = all_issued_q;
    frame_done_d = 1'b0;
    frame_start  = 1'b0;
    byte_start   = 1'b0;
    wrap         = (REPORT_PERIOD != 24'd0) && (period_q == REPORT_PERIOD - 24'd1);
    period_d     = (REPORT_PERIOD == 24'd0 || wrap) ? 24'd0 : period_q + 24'd1;
    case (state_q)
      F_IDLE: begin
        if (pending_q) begin
          frame_start  = 1'b1;
          state_d      = F_SEND;
          snap_d       = snap_in;
          issue_idx_d  = 3'd0;
          all_issued_d = 1'b0;
        end
      end
      F_SEND: begin
        // Hand the next byte over whenever the serializer can take it.
        if (!all_issued_q && byte_ready) begin
          byte_start  = 1'b1;
          issue_idx_d = issue_idx_q + 3'd1;
          if (issue_idx_q == LAST_IDX) begin
            all_issued_d = 1'b1;
          end
        end
        // The only done seen after the last hand-over is the final stop bit.
        if (all_issued_q && byte_done) begin
          frame_done_d = 1'b1;
          state_d      = F_IDLE;
        end
      end
      default: state_d = F_IDLE;
    endcase
    // A new request in the start cycle survives the clear.
    pending_d = (pending_q && !frame_start) || bus.send_req || wrap;
  end

  // Frame-level state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= F_IDLE;
      snap_q       <= '0;
      issue_idx_q  <= 3'd0;
      all_issued_q <= 1'b0;
      pending_q    <= 1'b0;
      period_q     <= 24'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      issue_idx_q  <= issue_idx_d;
      all_issued_q <= all_issued_d;
      pending_q    <= pending_d;
      period_q     <= period_d;
      frame_done_q <= frame_done_d;
    end
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .data  (frame_byte(snap_q, issue_idx_q)),
    .tx    (byte_tx),
    .ready (byte_ready),
    .done  (byte_done)
  );

  assign bus.uart_tx    = byte_tx;
  assign bus.busy       = (state_q == F_SEND);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_stats_uart_tx.sv
// Bench for stats_uart_tx: table-driven frames on an on-demand instance plus
// hand-written corner sequences; a second instance covers periodic reports.
module tb_stats_uart_tx;

  localparam int CPB = 4;
`ifdef STATS_TX_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int FLEN = NB * 10 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  stats_uart_tx_if ifa ();
  stats_uart_tx_if ifb ();

  stats_uart_tx #(.CLKS_PER_BIT(CPB), .REPORT_PERIOD(24'd0)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa));
  stats_uart_tx #(.CLKS_PER_BIT(CPB), .REPORT_PERIOD(24'd1000)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb));

  int errors = 0;
  int checks = 0;
  logic [7:0] expq_a[$];
  logic [7:0] expq_b[$];

  typedef struct {
    logic [3:0] hu, ha, he, hy, en, so;
    logic [6:0] st;
    logic [7:0] b1, b2, b3, b4;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic tx_of(input int w);
    return (w == 0) ? ifa.uart_tx : ifb.uart_tx;
  endfunction

  function automatic logic rst_of(input int w);
    return (w == 0) ? rst_a : rst_b;
  endfunction

  task automatic push_frame(input int w, input vec_t v);
    logic [7:0] fr[6];
    fr[0] = 8'hA5; fr[1] = v.b1; fr[2] = v.b2; fr[3] = v.b3; fr[4] = v.b4;
    fr[5] = 8'hA5 ^ v.b1 ^ v.b2 ^ v.b3 ^ v.b4;
    for (int i = 0; i < NB; i++) begin
      if (w == 0) expq_a.push_back(fr[i]);
      else        expq_b.push_back(fr[i]);
    end
  endtask

  task automatic set_in(input int w, input vec_t v);
    if (w == 0) begin
      ifa.hunger = v.hu; ifa.happiness = v.ha; ifa.health = v.he;
      ifa.hygiene = v.hy; ifa.energy = v.en; ifa.social = v.so; ifa.status = v.st;
    end else begin
      ifb.hunger = v.hu; ifb.happiness = v.ha; ifb.health = v.he;
      ifb.hygiene = v.hy; ifb.energy = v.en; ifb.social = v.so; ifb.status = v.st;
    end
  endtask

  // Called on the first low cycle of a start bit; samples each bit mid-period.
  task automatic rx_byte(input int w, output logic [7:0] b, output bit ok, output bit ab);
    ab = 1'b0; ok = 1'b1; b = 8'h00;
    for (int i = 0; i < CPB / 2; i++) begin
      @(negedge clk);
      if (rst_of(w)) ab = 1'b1;
    end
    if (tx_of(w) !== 1'b0) ok = 1'b0;
    for (int bi = 0; bi < 8; bi++) begin
      for (int i = 0; i < CPB; i++) begin
        @(negedge clk);
        if (rst_of(w)) ab = 1'b1;
      end
      b[bi] = tx_of(w);
    end
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (rst_of(w)) ab = 1'b1;
    end
    if (tx_of(w) !== 1'b1) ok = 1'b0;
  endtask

  // Line monitors: decode every byte and compare against the scoreboard queue.
  initial begin : mon_a
    logic [7:0] b, e;
    bit ok, ab;
    forever begin
      @(negedge clk);
      if (!rst_a && ifa.uart_tx === 1'b0) begin
        rx_byte(0, b, ok, ab);
        if (!ab) begin
          checks++;
          if (expq_a.size() == 0) begin
            errors++;
            $display("FAIL byte_a unexpected: got=%02h", b);
          end else begin
            e = expq_a.pop_front();
            if (!ok || b !== e) begin
              errors++;
              $display("FAIL byte_a: got=%02h framing_ok=%0d expected=%02h", b, ok, e);
            end
          end
        end
      end
    end
  end

  initial begin : mon_b
    logic [7:0] b, e;
    bit ok, ab;
    forever begin
      @(negedge clk);
      if (!rst_b && ifb.uart_tx === 1'b0) begin
        rx_byte(1, b, ok, ab);
        if (!ab) begin
          checks++;
          if (expq_b.size() == 0) begin
            errors++;
            $display("FAIL byte_b unexpected: got=%02h", b);
          end else begin
            e = expq_b.pop_front();
            if (!ok || b !== e) begin
              errors++;
              $display("FAIL byte_b: got=%02h framing_ok=%0d expected=%02h", b, ok, e);
            end
          end
        end
      end
    end
  end

  // Entered just after send_req was raised at a negedge; k=0 is the next negedge.
  task automatic watch_a(input int r0, input int r1, input int r2, input int chg_at,
                         output int busy_cyc, output int done_cnt, output int done1,
                         output int rise2, output int tx_low);
    int last;
    logic prev;
    busy_cyc = 0; done_cnt = 0; done1 = -1; rise2 = -1; tx_low = -1; last = -1; prev = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      ifa.send_req = (k == r0) || (k == r1) || (k == r2);
      if (k == chg_at) begin
        ifa.hunger = 4'h0; ifa.happiness = 4'h0; ifa.health = 4'h0; ifa.hygiene = 4'h0;
        ifa.energy = 4'h0; ifa.social = 4'h0; ifa.status = 7'h00;
      end
      if (ifa.busy === 1'b1) busy_cyc++;
      if (ifa.busy === 1'b1 && !prev && done1 >= 0 && rise2 < 0) rise2 = k;
      prev = ifa.busy;
      if (ifa.uart_tx === 1'b0 && tx_low < 0) tx_low = k;
      if (ifa.frame_done === 1'b1) begin
        done_cnt++;
        if (done1 < 0) done1 = k;
        last = k;
      end
      if (last >= 0 && k >= last + 3 && ifa.busy !== 1'b1) break;
    end
  endtask

  initial begin : main
    int busy_cyc, done_cnt, done1, rise2, tx_low, bad;
    int rises[$];
    int dones[$];
    logic prev_b;

    vecs[0] = '{4'h3, 4'hC, 4'hF, 4'h1, 4'h8, 4'h2, 7'h45, 8'h3C, 8'hF1, 8'h82, 8'h45};
    vecs[1] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 7'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    vecs[3] = '{4'hA, 4'h5, 4'h6, 4'h9, 4'h0, 4'hE, 7'h2A, 8'hA5, 8'h69, 8'h0E, 8'h2A};

    set_in(0, vecs[1]);
    set_in(1, vecs[1]);
    ifa.send_req = 1'b0;
    ifb.send_req = 1'b0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_a", ifa.uart_tx, 1);
    chk("rst_busy_a", ifa.busy, 0);
    chk("rst_done_a", ifa.frame_done, 0);
    chk("rst_tx_b", ifb.uart_tx, 1);
    rst_a = 1'b0;
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (ifa.uart_tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.frame_done !== 1'b0) bad++;
    end
    chk("idle_500", bad, 0);

    // Table of single-request frames.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_in(0, vecs[i]);
      push_frame(0, vecs[i]);
      ifa.send_req = 1'b1;
      watch_a(-1, -1, -1, -1, busy_cyc, done_cnt, done1, rise2, tx_low);
      chk($sformatf("v%0d_latency", i), tx_low, 2);
      // busy spans the snapshot cycle plus the whole line frame.
      chk($sformatf("v%0d_busy_len", i), busy_cyc, FLEN + 1);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("v%0d_frame_len", i), done1 - tx_low, FLEN);
      chk($sformatf("v%0d_bytes_left", i), expq_a.size(), 0);
    end

    // Inputs cleared one bit period after the start bit: snapshot is sent.
    @(negedge clk);
    set_in(0, vecs[0]);
    push_frame(0, vecs[0]);
    ifa.send_req = 1'b1;
    watch_a(-1, -1, -1, 2 + CPB, busy_cyc, done_cnt, done1, rise2, tx_low);
    chk("snap_done_cnt", done_cnt, 1);
    chk("snap_bytes_left", expq_a.size(), 0);

    // Three requests during a frame coalesce into one follow-up frame.
    @(negedge clk);
    set_in(0, vecs[3]);
    push_frame(0, vecs[3]);
    push_frame(0, vecs[3]);
    ifa.send_req = 1'b1;
    watch_a(50, 100, 150, -1, busy_cyc, done_cnt, done1, rise2, tx_low);
    chk("coal_done_cnt", done_cnt, 2);
    chk("coal_restart", rise2 - done1, 1);
    chk("coal_busy_len", busy_cyc, 2 * (FLEN + 1));
    chk("coal_bytes_left", expq_a.size(), 0);

    // Request still high on the frame-start cycle keeps pending set.
    @(negedge clk);
    set_in(0, vecs[2]);
    push_frame(0, vecs[2]);
    push_frame(0, vecs[2]);
    ifa.send_req = 1'b1;
    watch_a(0, -1, -1, -1, busy_cyc, done_cnt, done1, rise2, tx_low);
    chk("same_cyc_done_cnt", done_cnt, 2);
    chk("same_cyc_restart", rise2 - done1, 1);
    chk("same_cyc_bytes_left", expq_a.size(), 0);

    // Reset during data bit 2 of B2.
    @(negedge clk);
    set_in(0, vecs[0]);
    push_frame(0, vecs[0]);
    ifa.send_req = 1'b1;
    for (int k = 0; k <= 2 + 20 * CPB + CPB + 2 * CPB; k++) begin
      @(negedge clk);
      ifa.send_req = 1'b0;
    end
    chk("midrst_busy_before", ifa.busy, 1);
    chk("midrst_bytes_pending", expq_a.size(), NB - 2);
    rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_tx", ifa.uart_tx, 1);
    chk("midrst_busy", ifa.busy, 0);
    @(negedge clk);
    rst_a = 1'b0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ifa.uart_tx !== 1'b1 || ifa.busy !== 1'b0) bad++;
    end
    chk("midrst_idle_after", bad, 0);
    expq_a.delete();

    // Periodic reports every 1000 cycles; a wrap during a requested frame queues one more.
    set_in(1, vecs[3]);
    for (int i = 0; i < 4; i++) push_frame(1, vecs[3]);
    @(negedge clk);
    rst_b = 1'b0;
    prev_b = 1'b0;
    for (int k = 0; k < 3600; k++) begin
      @(negedge clk);
      ifb.send_req = (k == 2900);
      if (ifb.busy === 1'b1 && !prev_b) rises.push_back(k);
      prev_b = ifb.busy;
      if (ifb.frame_done === 1'b1) dones.push_back(k);
    end
    chk("per_rises", rises.size(), 4);
    chk("per_dones", dones.size(), 4);
    if (rises.size() >= 4 && dones.size() >= 3) begin
      chk("per_first", rises[0], 1000);
      chk("per_spacing", rises[1] - rises[0], 1000);
      chk("per_req_start", rises[2], 2902);
      chk("per_wrap_queued", rises[3] - dones[2], 1);
      chk("per_busy_len", dones[1] - rises[1], FLEN + 1);
    end
    chk("per_bytes_left", expq_b.size(), 0);
    rst_b = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
